// File: rtl/line_buffer_apb_pkg.sv
// Shared types and defaults for the line_buffer APB arbiter/sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_buffer_apb_pkg;

  // APB sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

endpackage

// File: rtl/line_buffer_rr_arb.sv
// Round-robin pick: rotate requests so ptr is bit 0, pick the lowest set bit, rotate the index back.
// Latency: purely combinational.
// Backpressure: no grant when i_en is low; grant is one-hot or zero.
module line_buffer_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  input  logic                       i_en,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_gnt_vld
);

  localparam int            IW   = $clog2(NUM_REQ);
  localparam logic [IW:0]   NREQ = (IW+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IW-1:0]        w_off;
  logic                 w_hit;
  logic [IW:0]          w_sum;

  // Rotate the request vector so the requester at ptr lands on bit 0
  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_rot = w_dbl[NUM_REQ-1:0];
  end

  // Fixed priority on the rotated vector: lowest offset from ptr wins
  always_comb begin
    w_off = '0;
    w_hit = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IW'(k);
        w_hit = 1'b1;
      end
    end
  end

  // Rotate the winning offset back to an absolute index; wrap by explicit compare
  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= NREQ) begin
      w_sum = w_sum - NREQ;
    end
    o_gnt_idx = w_sum[IW-1:0];
    o_gnt_vld = i_en & w_hit;
    o_gnt     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_gnt[i] = o_gnt_vld & (o_gnt_idx == IW'(i));
    end
  end

endmodule

// File: rtl/line_buffer_apb_arb.sv
// Round-robin arbiter sharing one zero-wait APB slave; each grant runs SETUP then ACCESS.
// Latency: grant c0, SETUP c1, ACCESS c2, rsp_valid c3; back-to-back gives one transfer per 2 cycles.
// Backpressure: requesters hold valid until a one-hot ready pulse; grants only in IDLE/ACCESS cycles.
module line_buffer_apb_arb
  import line_buffer_apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW
) (
  input  logic                  i_pclk,
  input  logic                  i_presetn,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_write,
  input  logic [NUM_REQ*AW-1:0] i_req_addr,
  input  logic [NUM_REQ*DW-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_busy,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [AW-1:0]         o_paddr,
  output logic [DW-1:0]         o_pwdata,
  input  logic [DW-1:0]         i_prdata
);

  localparam int            IW       = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  apb_state_e           r_state;
  apb_state_e           w_nxt_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        w_gnt_idx;
  logic [NUM_REQ-1:0]   w_gnt;
  logic                 w_gnt_vld;
  logic                 w_grant_en;
  logic                 w_done;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic                 w_sel_write;
  logic [AW-1:0]        w_sel_addr;
  logic [DW-1:0]        w_sel_wdata;

  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [AW-1:0]        r_paddr;
  logic [DW-1:0]        r_pwdata;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DW-1:0]        r_rsp_rdata;

  // Grants are only offered when the bus can take a new SETUP next cycle; inputs ignored in reset
  assign w_grant_en = i_presetn & ((r_state == ST_IDLE) | (r_state == ST_ACCESS));

  line_buffer_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .i_req     (i_req_valid),
    .i_ptr     (r_ptr),
    .i_en      (w_grant_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  // State register
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state: a grant always starts a SETUP, ACCESS either chains into the next SETUP or idles
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:   w_nxt_state = w_gnt_vld ? ST_SETUP : ST_IDLE;
      ST_SETUP:  w_nxt_state = ST_ACCESS;
      ST_ACCESS: w_nxt_state = w_gnt_vld ? ST_SETUP : ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  // State-derived strobes: completion in ACCESS, owner decode for the response strobe
  always_comb begin
    w_done     = (r_state == ST_ACCESS);
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_owner_oh[i] = (r_owner == IW'(i));
    end
  end

  // Mux the granted requester's payload
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_write = i_req_write[i];
        w_sel_addr  = i_req_addr[i*AW +: AW];
        w_sel_wdata = i_req_wdata[i*DW +: DW];
      end
    end
  end

  // Pointer and owner: ptr moves past the winner so it yields to others next time
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_gnt_vld) begin
      r_owner <= w_gnt_idx;
      r_ptr   <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + IW'(1);
    end
  end

  // APB bus registers: select/enable follow the next state, payload loads on grant and holds otherwise
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_psel    <= (w_nxt_state != ST_IDLE);
      r_penable <= (w_nxt_state == ST_ACCESS);
      if (w_gnt_vld) begin
        r_pwrite <= w_sel_write;
        r_paddr  <= w_sel_addr;
        r_pwdata <= w_sel_wdata;
      end
    end
  end

  // Response: one-cycle strobe to the owner at the ACCESS edge; data holds until the next completion
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid <= w_owner_oh;
        r_rsp_rdata <= r_pwrite ? '0 : i_prdata;
      end
    end
  end

  assign o_req_ready = w_gnt;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_busy      = r_psel;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;

endmodule

// File: tb/tb_line_buffer_apb_arb.sv
// Bench for line_buffer_apb_arb (3 requesters): directed scenarios then random traffic vs a timeline model.
// Latency: model expects SETUP at grant+1, ACCESS at grant+2, response at grant+3.
// Backpressure: requesters hold valid until granted, sometimes withdraw.
module tb_line_buffer_apb_arb;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_busy, o_psel, o_penable, o_pwrite;
  logic [AW-1:0]   o_paddr;
  logic [DW-1:0]   o_pwdata;
  logic [DW-1:0]   prdata;

  line_buffer_apb_arb #(.NUM_REQ(N), .AW(AW), .DW(DW)) u_dut (
    .i_pclk      (pclk),
    .i_presetn   (presetn),
    .i_req_valid (req_valid),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_busy      (o_busy),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_pwrite    (o_pwrite),
    .o_paddr     (o_paddr),
    .o_pwdata    (o_pwdata),
    .i_prdata    (prdata)
  );

  initial forever #5 pclk = ~pclk;

  typedef struct {
    bit            v;
    int            idx;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: transfers granted 1, 2 and 3 cycles ago, last granted payload, rr pointer
  txn_t          h1, h2, h3, lastg;
  int            m_ptr = 0;
  int            mg    = -1;
  logic [DW-1:0] e_rdata     = '0;
  logic [DW-1:0] prdata_prev = '0;
  logic [N-1:0]  dut_rdy;
  int            dut_gq[$];

  function automatic txn_t no_txn();
    txn_t t;
    t.v = 1'b0; t.idx = 0; t.wr = 1'b0; t.a = '0; t.d = '0;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_cycle();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rsp;
    txn_t         g;
    int           pick;
    e_rdy = '0;
    e_rsp = '0;
    pick  = -1;
    g     = no_txn();
    if (!presetn) begin
      h1 = no_txn(); h2 = no_txn(); h3 = no_txn(); lastg = no_txn();
      m_ptr   = 0;
      e_rdata = '0;
    end else begin
      if (h3.v) begin
        e_rsp[h3.idx] = 1'b1;
        e_rdata = h3.wr ? '0 : prdata_prev;
      end
      // a new grant is possible in any cycle that is not a SETUP cycle
      if (!h1.v) begin
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        end
      end
      if (pick >= 0) e_rdy[pick] = 1'b1;
    end
    chk("req_ready", 64'(o_req_ready), 64'(e_rdy));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(e_rsp));
    chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e_rdata));
    chk("psel",      64'(o_psel),      64'(h1.v || h2.v));
    chk("penable",   64'(o_penable),   64'(h2.v));
    chk("busy",      64'(o_busy),      64'(h1.v || h2.v));
    chk("pwrite",    64'(o_pwrite),    64'(lastg.wr));
    chk("paddr",     64'(o_paddr),     64'(lastg.a));
    chk("pwdata",    64'(o_pwdata),    64'(lastg.d));
    mg = pick;
    if (pick >= 0) begin
      g.v   = 1'b1;
      g.idx = pick;
      g.wr  = req_write[pick];
      g.a   = req_addr[pick*AW +: AW];
      g.d   = req_wdata[pick*DW +: DW];
      lastg = g;
      m_ptr = (pick + 1) % N;
    end
    h3 = h2; h2 = h1; h1 = g;
    prdata_prev = prdata;
  endtask

  task automatic step();
    @(negedge pclk);
    dut_rdy = o_req_ready;
    for (int i = 0; i < N; i++) if (o_req_ready[i]) dut_gq.push_back(i);
    model_cycle();
    cyc++;
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_steps(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (mg == i) req_valid[i] = 1'b0;
      if (req_valid[i]) begin
        if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(1) == 1) begin
        set_req(i, 1'($urandom_range(1)), $urandom, $urandom);
      end
    end
    prdata  = $urandom;
    presetn = ($urandom_range(199) != 0);
  endtask

  initial begin
    presetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    h1 = no_txn(); h2 = no_txn(); h3 = no_txn(); lastg = no_txn();
    step();
    step();
    presetn = 1'b1;

    // single read from requester 0
    prdata = 32'hDEADBEEF;
    set_req(0, 1'b0, 32'h10, 32'h0);
    step();
    chk("t1_ready", 64'(dut_rdy), 64'(3'b001));
    idle_steps(3);
    chk("t1_rdata", 64'(o_rsp_rdata), 64'h0000_0000_DEAD_BEEF);

    // single write from requester 1
    prdata = 32'h1234_5678;
    set_req(1, 1'b1, 32'h24, 32'h5A5A0001);
    step();
    idle_steps(3);
    chk("t2_paddr",  64'(o_paddr),     64'h24);
    chk("t2_pwdata", 64'(o_pwdata),    64'h5A5A0001);
    chk("t2_rdata",  64'(o_rsp_rdata), 64'h0);

    // contention between 0 and 1, held for 6 transfers
    dut_gq.delete();
    set_req(0, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 32'h200, 32'hA5);
    for (int i = 0; i < 11; i++) begin
      prdata = $urandom;
      step();
    end
    idle_steps(3);
    chk("t3_count", 64'(dut_gq.size()), 64'd6);
    for (int k = 0; k < dut_gq.size() && k < 6; k++) chk("t3_order", 64'(dut_gq[k]), 64'(k % 2));

    // fairness: requester 0 re-asserts in its response cycle alongside a new requester 1
    set_req(0, 1'b0, 32'h300, 32'h0);
    step();
    req_valid = '0;
    step();
    step();
    set_req(0, 1'b0, 32'h304, 32'h0);
    set_req(1, 1'b0, 32'h308, 32'h0);
    step();
    chk("t4_fair", 64'(dut_rdy), 64'(3'b010));
    req_valid[1] = 1'b0;
    step();
    step();
    idle_steps(4);

    // reset asserted during ACCESS
    set_req(0, 1'b1, 32'h400, 32'h77);
    step();
    req_valid = '0;
    step();
    chk("t5_pen_pre", 64'(o_penable), 64'd1);
    #1 presetn = 1'b0;
    #1;
    chk("t5_psel_async", 64'(o_psel), 64'd0);
    chk("t5_pen_async",  64'(o_penable), 64'd0);
    step();
    presetn = 1'b1;
    set_req(0, 1'b0, 32'h500, 32'h0);
    set_req(1, 1'b0, 32'h504, 32'h0);
    step();
    chk("t5_first_gnt", 64'(dut_rdy), 64'(3'b001));
    req_valid[0] = 1'b0;
    step();
    step();
    idle_steps(4);

    // all three requesting from a fresh pointer
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    dut_gq.delete();
    set_req(0, 1'b0, 32'h600, 32'h0);
    set_req(1, 1'b1, 32'h604, 32'h11);
    set_req(2, 1'b0, 32'h608, 32'h0);
    for (int i = 0; i < 13; i++) begin
      prdata = $urandom;
      step();
    end
    idle_steps(4);
    chk("t6_count", 64'(dut_gq.size()), 64'd7);
    for (int k = 0; k < dut_gq.size() && k < 7; k++) chk("t6_order", 64'(dut_gq[k]), 64'(k % 3));

    // random traffic with occasional resets
    mg = -1;
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    presetn = 1'b1;
    idle_steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
